xbus_arbiter: RTL and testbench



---
 rtl/xbus_pkg.sv | 17 +
 rtl/xbus_rr_arbiter.sv | 43 ++++
 rtl/xbus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_xbus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// Shared Xbus types and default parameters.
package xbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    ACK  = 2'd2
  } xbus_state_t;

  localparam int unsigned XBUS_NM       = 2;
  localparam int unsigned XBUS_NS       = 6;
  localparam int unsigned XBUS_AW       = 22;
  localparam int unsigned XBUS_DW       = 32;
  localparam int unsigned XBUS_TMO      = 63;
  localparam bit          XBUS_CPU_PRIO = 1'b1;

endpackage

// File: rtl/xbus_rr_arbiter.sv
// Combinational master selection: optional CPU priority, round-robin otherwise.
module xbus_rr_arbiter #(
  parameter int unsigned NM       = 2,
  parameter bit          CPU_PRIO = 1'b1
) (
  input  logic [NM-1:0]         req,
  input  logic [$clog2(NM)-1:0] rr_ptr,
  output logic [NM-1:0]         gnt,
  output logic                  ptr_load,
  output logic [$clog2(NM)-1:0] ptr_next
);
  localparam int unsigned PW = $clog2(NM);

  int unsigned     idx_i;
  logic [PW-1:0]   idx;
  logic            found;

  // With CPU_PRIO=0 master 0 is part of the rotation, so every grant advances the pointer.
  always_comb begin
    gnt      = '0;
    ptr_load = 1'b0;
    ptr_next = rr_ptr;
    found    = 1'b0;
    idx_i    = 0;
    idx      = '0;
    if (CPU_PRIO && req[0]) begin
      gnt[0] = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NM; k++) begin
        idx_i = int'(rr_ptr) + k;
        if (idx_i >= NM) idx_i = idx_i - NM;
        idx = PW'(idx_i);
        if (!found && req[idx] && !(CPU_PRIO && idx == '0)) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
          ptr_load = 1'b1;
          ptr_next = idx;
        end
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// Multi-master Xbus interconnect: arbitration, slave routing, timeout and error capture.
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int unsigned NM       = XBUS_NM,
  parameter int unsigned NS       = XBUS_NS,
  parameter int unsigned AW       = XBUS_AW,
  parameter int unsigned DW       = XBUS_DW,
  parameter int unsigned TMO      = XBUS_TMO,
  parameter bit          CPU_PRIO = XBUS_CPU_PRIO
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic [NM-1:0]         m_req,
  input  logic [NM-1:0]         m_write,
  input  logic [NM*AW-1:0]      m_addr,
  input  logic [NM*DW-1:0]      m_wdata,
  output logic [NM-1:0]         m_ack,
  output logic [NM-1:0]         m_load,
  output logic [NM-1:0]         m_err,
  output logic [DW-1:0]         m_rdata,
  output logic                  s_req,
  output logic                  s_write,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  input  logic [NS-1:0]         s_decode,
  input  logic [NS-1:0]         s_ack,
  input  logic [NS*DW-1:0]      s_rdata,
  output logic [NM-1:0]         grant,
  output logic [AW-1:0]         err_addr,
  output logic [$clog2(NM)-1:0] err_master,
  output logic [1:0]            bus_state
);
  localparam int unsigned MW = $clog2(NM);
  localparam int unsigned CW = $clog2(TMO + 1);

  xbus_state_t   state, state_nxt;
  logic [NM-1:0] arb_gnt;
  logic          ptr_load;
  logic [MW-1:0] ptr_next, rr_ptr;
  logic [MW-1:0] arb_idx, gidx;
  logic [CW-1:0] cnt;
  logic          req_g, tmo_hit, go_ack, go_err;
  logic          fail, rd_pend;
  logic [DW-1:0] ack_data;

  xbus_rr_arbiter #(
    .NM       (NM),
    .CPU_PRIO (CPU_PRIO)
  ) u_arb (
    .req      (m_req),
    .rr_ptr   (rr_ptr),
    .gnt      (arb_gnt),
    .ptr_load (ptr_load),
    .ptr_next (ptr_next)
  );

  // Encode the arbiter's one-hot winner into an index.
  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NM; i++)
      if (arb_gnt[i]) arb_idx = MW'(i);
  end

  // Route the granted master's cycle to the slave side.
  always_comb begin
    s_write = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    req_g   = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (grant[i]) begin
        s_write = m_write[i];
        s_addr  = m_addr[i*AW +: AW];
        s_wdata = m_wdata[i*DW +: DW];
        req_g   = m_req[i];
      end
    end
  end

  // Read data from the lowest-index acking slave.
  always_comb begin
    ack_data = '0;
    for (int unsigned k = NS; k > 0; k--)
      if (s_ack[k-1]) ack_data = s_rdata[(k-1)*DW +: DW];
  end

  // Counter value TMO-1 in ADDR means this is the TMO-th ADDR cycle.
  assign tmo_hit = (cnt == CW'(TMO - 1));

  // Next-state decode; slave ack outranks decode miss and timeout.
  always_comb begin
    state_nxt = state;
    go_ack    = 1'b0;
    go_err    = 1'b0;
    case (state)
      IDLE: if (|m_req) state_nxt = ADDR;
      ADDR: begin
        if (!req_g) begin
          state_nxt = IDLE;
        end else if (|s_ack) begin
          state_nxt = ACK;
          go_ack    = 1'b1;
        end else if (~|s_decode || tmo_hit) begin
          state_nxt = ACK;
          go_ack    = 1'b1;
          go_err    = 1'b1;
        end
      end
      ACK:  if (!req_g) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Master and slave handshake outputs.
  always_comb begin
    s_req  = (state == ADDR);
    m_ack  = (state == ACK) ? grant : '0;
    m_err  = (state == ACK && fail) ? grant : '0;
    m_load = (state == ACK && rd_pend) ? grant : '0;
  end

  assign bus_state = state;

  // State register.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grant ownership and round-robin pointer.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      grant  <= '0;
      gidx   <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE && |m_req) begin
      grant <= arb_gnt;
      gidx  <= arb_idx;
      if (ptr_load) rr_ptr <= ptr_next;
    end else if (state_nxt == IDLE) begin
      grant <= '0;
    end
  end

  // Saturating timeout counter.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset)                                  cnt <= '0;
    else if (state == IDLE)                     cnt <= '0;
    else if (state == ADDR && cnt != CW'(TMO))  cnt <= cnt + 1'b1;
  end

  // Completion status, read data and error capture.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      fail       <= 1'b0;
      rd_pend    <= 1'b0;
      m_rdata    <= '0;
      err_addr   <= '0;
      err_master <= '0;
    end else if (go_ack) begin
      fail    <= go_err;
      rd_pend <= !s_write;
      if (!s_write) m_rdata <= go_err ? '0 : ack_data;
      if (go_err) begin
        err_addr   <= s_addr;
        err_master <= gidx;
      end
    end else begin
      rd_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Scoreboard bench for xbus_arbiter with a behavioural slave population.
module tb_xbus_arbiter;
  localparam int unsigned NM  = 3;
  localparam int unsigned NS  = 6;
  localparam int unsigned AW  = 22;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 63;
  localparam bit          CPU_PRIO = 1'b1;
  localparam int unsigned MW  = $clog2(NM);

  logic                mclk = 1'b0;
  logic                reset;
  logic [NM-1:0]       m_req, m_write;
  logic [NM*AW-1:0]    m_addr;
  logic [NM*DW-1:0]    m_wdata;
  logic [NM-1:0]       m_ack, m_load, m_err;
  logic [DW-1:0]       m_rdata;
  logic                s_req, s_write;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic [NS-1:0]       s_decode, s_ack;
  logic [NS*DW-1:0]    s_rdata;
  logic [NM-1:0]       grant;
  logic [AW-1:0]       err_addr;
  logic [MW-1:0]       err_master;
  logic [1:0]          bus_state;

  xbus_arbiter #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .TMO(TMO), .CPU_PRIO(CPU_PRIO)
  ) dut (
    .mclk(mclk), .reset(reset),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_load(m_load), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_decode(s_decode), .s_ack(s_ack), .s_rdata(s_rdata),
    .grant(grant), .err_addr(err_addr), .err_master(err_master), .bus_state(bus_state)
  );

  // Address map: [21:19] slave (6,7 unmapped), [3] slave 5 also acks, [2] never ack, [1:0] wait.
  typedef struct {
    logic          err;
    logic          wr;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    int            lat;
    int            issue;
  } exp_t;

  exp_t          exp_q [NM][$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            wait_ovr = -1;
  int            addr_cyc = 0;
  int            mptr = 0;
  logic [AW-1:0] merr_addr = '0;
  int            merr_m = 0;
  logic [NM-1:0] prev_ack = '0;
  logic [NM-1:0] prev_grant = '0;
  exp_t          mon_e;
  int            mon_w;
  logic [NM-1:0] mon_oh;

  initial forever #5 mclk = ~mclk;
  initial forever begin @(posedge mclk); cyc = cyc + 1; end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] slave_data(int unsigned k, logic [AW-1:0] a);
    if (k == 2 && a[18:4] == '0) return 32'h1234_5678;
    return {8'(k), 2'b00, a};
  endfunction

  function automatic exp_t model_resp(logic [AW-1:0] a, logic wr, int wt_ovr, int issue, bit chk_lat);
    exp_t        e;
    int unsigned slv;
    int          wt;
    slv = a[21:19];
    e.addr = a; e.wr = wr; e.issue = issue; e.err = 1'b0; e.rdata = '0;
    if (wt_ovr >= 0) wt = wt_ovr;
    else             wt = a[2] ? 1000000 : int'(a[1:0]);
    if (slv >= NS) begin
      e.err = 1'b1; e.lat = 2;
    end else if (wt + 1 > int'(TMO)) begin
      e.err = 1'b1; e.lat = int'(TMO) + 1;
    end else begin
      e.lat = wt + 2;
      if (!wr) e.rdata = slave_data(slv, a);
    end
    if (!chk_lat) e.lat = -1;
    return e;
  endfunction

  function automatic int pick(logic [NM-1:0] req, int ptr);
    int order[$];
    if (CPU_PRIO && req[0]) return 0;
    for (int k = 1; k <= int'(NM); k++) order.push_back((ptr + k) % int'(NM));
    foreach (order[j])
      if (req[order[j]] && !(CPU_PRIO && order[j] == 0)) return order[j];
    return -1;
  endfunction

  // Slave population.
  always_comb begin
    s_decode = '0;
    if (s_addr[21:19] < NS) s_decode[s_addr[21:19]] = 1'b1;
    for (int k = 0; k < int'(NS); k++) s_rdata[k*DW +: DW] = slave_data(k, s_addr);
  end

  initial begin
    int unsigned slv;
    int          wt;
    s_ack = '0;
    forever begin
      @(negedge mclk);
      if (s_req) begin
        addr_cyc++;
        slv = s_addr[21:19];
        if (wait_ovr >= 0) wt = wait_ovr;
        else               wt = s_addr[2] ? 1000000 : int'(s_addr[1:0]);
        s_ack = '0;
        if (slv < NS && addr_cyc >= wt + 1) begin
          s_ack[slv] = 1'b1;
          if (s_addr[3] && slv < 5) s_ack[5] = 1'b1;
        end
      end else begin
        addr_cyc = 0;
        s_ack    = '0;
      end
    end
  end

  // Monitor: grant arbitration and ack responses against the scoreboard.
  initial begin
    forever begin
      @(posedge mclk); #1;
      if (reset) begin
        prev_ack = '0; prev_grant = '0; mptr = 0; merr_addr = '0; merr_m = 0;
      end else begin
        if (grant != '0 && prev_grant == '0) begin
          mon_w  = pick(m_req, mptr);
          mon_oh = '0;
          if (mon_w >= 0) mon_oh[mon_w] = 1'b1;
          chk("grant", grant, mon_oh);
          if (mon_w > 0) mptr = mon_w;
          if (mon_w >= 0) begin
            chk("s_req", s_req, 1'b1);
            chk("s_addr", s_addr, m_addr[mon_w*AW +: AW]);
            chk("s_write", s_write, m_write[mon_w]);
            chk("s_wdata", s_wdata, m_wdata[mon_w*DW +: DW]);
          end
        end
        for (int i = 0; i < int'(NM); i++) begin
          if (m_ack[i] && !prev_ack[i]) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_ack m%0d actual=ack required=none", i);
            end else begin
              mon_e = exp_q[i].pop_front();
              chk("m_err", m_err[i], mon_e.err);
              if (mon_e.wr) chk("m_load_wr", m_load[i], 1'b0);
              else begin
                chk("m_load", m_load[i], 1'b1);
                chk("m_rdata", m_rdata, mon_e.rdata);
              end
              if (mon_e.lat >= 0) chk("latency", cyc - mon_e.issue, mon_e.lat);
              if (mon_e.err) begin merr_addr = mon_e.addr; merr_m = i; end
              chk("err_addr", err_addr, merr_addr);
              chk("err_master", err_master, merr_m);
            end
          end else if (m_ack[i] && prev_ack[i]) begin
            chk("m_load_2nd", m_load[i], 1'b0);
          end
        end
        prev_ack   = m_ack;
        prev_grant = grant;
      end
    end
  end

  task automatic xfer(int m, logic wr, logic [AW-1:0] a, bit chk_lat, int wt_ovr, int hold);
    int n;
    @(negedge mclk);
    m_write[m] = wr;
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = $urandom();
    exp_q[m].push_back(model_resp(a, wr, wt_ovr, cyc, chk_lat));
    m_req[m] = 1'b1;
    n = 0;
    while (!m_ack[m] && n < 400) begin @(negedge mclk); n++; end
    if (!m_ack[m]) begin
      checks++; errors++;
      $display("FAIL ack_wait m%0d actual=no_ack required=ack", m);
    end
    repeat (hold) @(negedge mclk);
    m_req[m] = 1'b0;
    n = 0;
    while (m_ack[m] && n < 20) begin @(negedge mclk); n++; end
  endtask

  function automatic logic [AW-1:0] mk_addr(int slv, bit extra, bit never, int wt);
    logic [14:0] mid;
    mid = 15'($urandom());
    return {3'(slv), mid, extra, never, 2'(wt)};
  endfunction

  task automatic rr_run(int m, int n);
    for (int t = 0; t < n; t++)
      xfer(m, 1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 5), 1'b0, 1'b0, $urandom_range(0, 3)), 1'b0, -1, 0);
  endtask

  task automatic rand_run(int m, int n);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge mclk);
      xfer(m, 1'($urandom_range(0, 1)),
           mk_addr($urandom_range(0, 7), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), $urandom_range(0, 3)),
           1'b0, -1, $urandom_range(0, 2));
    end
  endtask

  initial begin
    int n;
    m_req = '0; m_write = '0; m_addr = '0; m_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge mclk); #1;
    chk("rst_grant", grant, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_load", m_load, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_req", s_req, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_master", err_master, 0);
    chk("rst_bus_state", bus_state, 0);
    @(negedge mclk);
    reset = 1'b0;

    xfer(0, 1'b0, {3'd2, 15'd0, 4'd0}, 1'b1, -1, 0);
    xfer(0, 1'b0, {3'd7, 15'h1abc, 4'd0}, 1'b1, -1, 0);
    xfer(1, 1'b0, {3'd3, 15'h0042, 4'b0100}, 1'b1, -1, 0);
    xfer(0, 1'b1, {3'd4, 15'h0077, 4'b0001}, 1'b1, -1, 0);
    xfer(2, 1'b0, {3'd1, 15'h0123, 4'b1010}, 1'b1, -1, 1);
    wait_ovr = int'(TMO) - 1;
    xfer(2, 1'b0, {3'd1, 15'h0011, 4'd0}, 1'b1, int'(TMO) - 1, 0);
    wait_ovr = int'(TMO);
    xfer(2, 1'b0, {3'd1, 15'h0022, 4'd0}, 1'b1, int'(TMO), 0);
    wait_ovr = -1;

    fork
      rr_run(1, 4);
      rr_run(2, 4);
    join
    fork
      rr_run(0, 3);
      rr_run(1, 3);
      rr_run(2, 3);
    join
    fork
      rand_run(0, 10);
      rand_run(1, 10);
      rand_run(2, 10);
    join

    @(negedge mclk);
    m_write[0] = 1'b0;
    m_addr[0 +: AW] = {3'd5, 15'h0, 4'b0100};
    m_req[0] = 1'b1;
    n = 0;
    while (!s_req && n < 20) begin @(negedge mclk); n++; end
    chk("reset_setup_s_req", s_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_s_req", s_req, 0);
    chk("async_rst_grant", grant, 0);
    chk("async_rst_state", bus_state, 0);
    m_req[0] = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    reset = 1'b0;
    xfer(0, 1'b0, {3'd2, 15'd0, 4'd0}, 1'b1, -1, 0);

    repeat (5) @(negedge mclk);
    for (int i = 0; i < int'(NM); i++) chk("queue_empty", exp_q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
